// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Register-file write-port arbiter. ALU writebacks take priority.
//            Multicycle mult/div results are bypassed when the queue is empty
//            and otherwise queued. A starvation monitor asks upstream to
//            stall so that the queue can drain.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [31:0] busy_mask,
  output logic        stall_req,
  output logic        err_collision
);

  localparam int                 c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam int                 c_cnt_w   = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [3:0]         c_limit   = 4'(STARVE_LIMIT);

  // Queue state
  logic [4:0]            slot_rd_q   [FIFO_DEPTH];
  logic [4:0]            slot_rd_d   [FIFO_DEPTH];
  logic [31:0]           slot_data_q [FIFO_DEPTH];
  logic [31:0]           slot_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0]    count_q, count_d;

  // Write port, monitor and flags
  logic        we_q, we_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] busy_q, busy_d;
  logic [3:0]  starve_q, starve_d;
  logic        stall_q, stall_d;
  logic        err_q, err_d;

  // Per-cycle selection decisions
  logic w_alu_sel, w_md_fire, w_q_empty, w_pop, w_bypass, w_push;

  // Ready depends only on registered occupancy, so it has no path from alu_valid.
  assign md_ready  = (count_q < c_depth);
  assign w_alu_sel = alu_valid && (alu_rd != 5'd0);
  assign w_md_fire = md_valid && md_ready;
  assign w_q_empty = (count_q == '0);
  assign w_pop     = !w_alu_sel && !w_q_empty;
  // Bypass only when nothing is queued, so a bypass never overtakes an older result.
  assign w_bypass  = !w_alu_sel && w_q_empty && w_md_fire && (md_rd != 5'd0);
  assign w_push    = w_md_fire && (md_rd != 5'd0) && !w_bypass;

  // Next queue contents, pointers, occupancy and the busy mask they imply.
  always_comb begin
    slot_rd_d   = slot_rd_q;
    slot_data_d = slot_data_q;
    vld_d       = vld_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    busy_d      = '0;
    if (w_pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + c_ptr_one;
    end
    if (w_push) begin
      slot_rd_d[wr_ptr_q]   = md_rd;
      slot_data_d[wr_ptr_q] = md_data;
      vld_d[wr_ptr_q]       = 1'b1;
      wr_ptr_d              = wr_ptr_q + c_ptr_one;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (vld_d[i]) busy_d[slot_rd_d[i]] = 1'b1;
    end
  end

  // Priority select for the registered write port; idle cycles hold reg/data.
  always_comb begin
    we_d    = 1'b1;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (w_alu_sel) begin
      wreg_d  = alu_rd;
      wdata_d = alu_data;
    end else if (w_pop) begin
      wreg_d  = slot_rd_q[rd_ptr_q];
      wdata_d = slot_data_q[rd_ptr_q];
    end else if (w_bypass) begin
      wreg_d  = md_rd;
      wdata_d = md_data;
    end else begin
      we_d = 1'b0;
    end
  end

  // Starvation counter, stall request and sticky collision flag.
  always_comb begin
    starve_d = starve_q;
    if (w_q_empty || w_pop) begin
      starve_d = 4'd0;
    end else if (starve_q < c_limit) begin
      starve_d = starve_q + 4'd1;
    end
    stall_d = (starve_d == c_limit);
    err_d   = err_q | (alu_valid & stall_q);
  end

  // Control state and outputs, cleared asynchronously by reset.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
    end
  end

  // Queue payload storage; validity is tracked separately, so no reset is needed.
  always_ff @(posedge clock) begin
    slot_rd_q   <= slot_rd_d;
    slot_data_q <= slot_data_d;
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;
  assign busy_mask        = busy_q;
  assign stall_req        = stall_q;
  assign err_collision    = err_q;

endmodule
`default_nettype wire
